// File: rtl/pulse_hold_multi.sv
// Multi-channel pulse stretcher: a rising trigger edge holds the channel output
// high for HOLD_SEC second ticks, followed by an optional GUARD_SEC lockout.
module pulse_hold_multi #(
  parameter int CH        = 4,
  parameter int HOLD_SEC  = 1,
  parameter int GUARD_SEC = 0,
  parameter int CNT_W     = 8,
  parameter int RETRIG    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sec_tick,
  input  logic [CH-1:0] trig_in,
  input  logic [CH-1:0] clr,
  output logic [CH-1:0] hold_out,
  output logic [CH-1:0] done,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HOLD  = CNT_W'(HOLD_SEC);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_SEC);

  // Reject parameter sets the counters cannot represent.
  if (CH < 1) begin : g_bad_ch
    $error("pulse_hold_multi: CH must be >= 1");
  end
  if (HOLD_SEC < 1) begin : g_bad_hold
    $error("pulse_hold_multi: HOLD_SEC must be >= 1");
  end
  if (GUARD_SEC < 0) begin : g_bad_guard
    $error("pulse_hold_multi: GUARD_SEC must be >= 0");
  end
  if (((HOLD_SEC >> CNT_W) != 0) || ((GUARD_SEC >> CNT_W) != 0)) begin : g_bad_cnt_w
    $error("pulse_hold_multi: CNT_W too narrow for HOLD_SEC/GUARD_SEC");
  end

  state_t           state_r  [CH];
  state_t           state_nx [CH];
  logic [CNT_W-1:0] cnt_r    [CH];
  logic [CNT_W-1:0] cnt_nx   [CH];
  logic [CH-1:0]    prev_r;
  logic [CH-1:0]    edge_s;
  logic [CH-1:0]    hold_r;
  logic [CH-1:0]    hold_nx;
  logic [CH-1:0]    done_r;
  logic [CH-1:0]    done_nx;
  logic             busy_r;
  logic             busy_nx;

  // Per-channel next-state: clr beats edge, edge in HOLD (retrigger) beats tick.
  always_comb begin
    edge_s  = trig_in & ~prev_r;
    done_nx = {CH{1'b0}};
    hold_nx = {CH{1'b0}};
    busy_nx = 1'b0;
    for (int i = 0; i < CH; i++) begin
      state_nx[i] = state_r[i];
      cnt_nx[i]   = cnt_r[i];
      if (clr[i]) begin
        state_nx[i] = ST_IDLE;
        cnt_nx[i]   = CNT_ZERO;
      end else begin
        case (state_r[i])
          ST_IDLE: begin
            if (edge_s[i]) begin
              state_nx[i] = ST_HOLD;
              cnt_nx[i]   = CNT_HOLD;
            end else begin
              cnt_nx[i]   = CNT_ZERO;
            end
          end
          ST_HOLD: begin
            if ((RETRIG != 0) && edge_s[i]) begin
              cnt_nx[i] = CNT_HOLD;
            end else if (sec_tick) begin
              if (cnt_r[i] == CNT_ONE) begin
                done_nx[i] = 1'b1;
                if (GUARD_SEC == 0) begin
                  state_nx[i] = ST_IDLE;
                  cnt_nx[i]   = CNT_ZERO;
                end else begin
                  state_nx[i] = ST_GUARD;
                  cnt_nx[i]   = CNT_GUARD;
                end
              end else begin
                cnt_nx[i] = cnt_r[i] - CNT_ONE;
              end
            end else begin
              cnt_nx[i] = cnt_r[i];
            end
          end
          ST_GUARD: begin
            if (sec_tick) begin
              if (cnt_r[i] == CNT_ONE) begin
                state_nx[i] = ST_IDLE;
                cnt_nx[i]   = CNT_ZERO;
              end else begin
                cnt_nx[i]   = cnt_r[i] - CNT_ONE;
              end
            end else begin
              cnt_nx[i] = cnt_r[i];
            end
          end
          default: begin
            state_nx[i] = ST_IDLE;
            cnt_nx[i]   = CNT_ZERO;
          end
        endcase
      end
      hold_nx[i] = (state_nx[i] == ST_HOLD);
      busy_nx    = busy_nx | (state_nx[i] != ST_IDLE);
    end
  end

  // State, counters and registered outputs; prev resets high to mask a trigger held through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        state_r[i] <= ST_IDLE;
        cnt_r[i]   <= CNT_ZERO;
      end
      prev_r <= {CH{1'b1}};
      hold_r <= {CH{1'b0}};
      done_r <= {CH{1'b0}};
      busy_r <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_r[i] <= state_nx[i];
        cnt_r[i]   <= cnt_nx[i];
      end
      prev_r <= trig_in;
      hold_r <= hold_nx;
      done_r <= done_nx;
      busy_r <= busy_nx;
    end
  end

  assign hold_out = hold_r;
  assign done     = done_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_pulse_hold_multi.sv
// Directed bench: two instances (retrigger on / off) share stimulus; HOLD=3, GUARD=2, ticks every 10 clk.
module tb_pulse_hold_multi;

  logic       clk;
  logic       rst_n;
  logic       sec_tick;
  logic [1:0] trig_in;
  logic [1:0] clr;
  logic [1:0] hold_rt, done_rt, hold_nr, done_nr;
  logic       busy_rt, busy_nr;

  int n_chk;
  int n_fail;

  pulse_hold_multi #(.CH(2), .HOLD_SEC(3), .GUARD_SEC(2), .CNT_W(8), .RETRIG(1)) u_dut_rt (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .trig_in(trig_in), .clr(clr),
    .hold_out(hold_rt), .done(done_rt), .busy(busy_rt)
  );

  pulse_hold_multi #(.CH(2), .HOLD_SEC(3), .GUARD_SEC(2), .CNT_W(8), .RETRIG(0)) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .trig_in(trig_in), .clr(clr),
    .hold_out(hold_nr), .done(done_nr), .busy(busy_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Same expectation on both instances.
  task automatic expect_both(input string tag, input logic [1:0] h, input logic [1:0] d, input logic b);
    check({tag, " rt hold"}, 32'(hold_rt), 32'(h));
    check({tag, " rt done"}, 32'(done_rt), 32'(d));
    check({tag, " rt busy"}, 32'(busy_rt), 32'(b));
    check({tag, " nr hold"}, 32'(hold_nr), 32'(h));
    check({tag, " nr done"}, 32'(done_nr), 32'(d));
    check({tag, " nr busy"}, 32'(busy_nr), 32'(b));
  endtask

  // One clock with the given inputs; outputs are observed 1 time unit after the edge.
  task automatic step(input logic [1:0] t, input logic [1:0] c, input logic tk);
    trig_in  = t;
    clr      = c;
    sec_tick = tk;
    @(posedge clk);
    #1;
    sec_tick = 1'b0;
    clr      = 2'b00;
  endtask

  // n periods of 9 quiet cycles followed by a tick cycle, trigger level unchanged.
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 9; j++) step(trig_in, 2'b00, 1'b0);
      step(trig_in, 2'b00, 1'b1);
    end
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    sec_tick = 1'b0;
    clr      = 2'b00;
    trig_in  = 2'b11;

    // Reset with both triggers high
    repeat (3) @(posedge clk);
    #1;
    expect_both("reset", 2'b00, 2'b00, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(2'b11, 2'b00, 1'b0);
    expect_both("no fire after reset", 2'b00, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    expect_both("ch1 edge", 2'b10, 2'b00, 1'b1);
    ticks(2);
    expect_both("ch1 mid hold", 2'b10, 2'b00, 1'b1);
    ticks(1);
    expect_both("ch1 end", 2'b00, 2'b10, 1'b1);
    step(2'b11, 2'b00, 1'b0);
    expect_both("ch1 guard", 2'b00, 2'b00, 1'b1);
    ticks(2);
    expect_both("ch1 idle", 2'b00, 2'b00, 1'b0);

    // Basic hold on ch0, edge 4 clk before a tick
    step(2'b10, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    expect_both("ch0 rise", 2'b01, 2'b00, 1'b1);
    for (int k = 0; k < 3; k++) step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b1);
    ticks(1);
    expect_both("ch0 after 2 ticks", 2'b01, 2'b00, 1'b1);
    ticks(1);
    expect_both("ch0 fall", 2'b00, 2'b01, 1'b1);
    step(2'b11, 2'b00, 1'b0);
    expect_both("ch0 done 1 cycle", 2'b00, 2'b00, 1'b1);

    // Guard lockout
    ticks(1);
    step(2'b10, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    expect_both("guard edge ignored", 2'b00, 2'b00, 1'b1);
    for (int k = 0; k < 6; k++) step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b1);
    expect_both("guard over", 2'b00, 2'b00, 1'b0);
    step(2'b10, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    expect_both("edge after guard", 2'b01, 2'b00, 1'b1);

    // Clear beats final tick and a new edge
    ticks(2);
    for (int k = 0; k < 8; k++) step(2'b10, 2'b00, 1'b0);
    step(2'b11, 2'b01, 1'b1);
    expect_both("clr priority", 2'b00, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    expect_both("no refire after clr", 2'b00, 2'b00, 1'b0);

    // Retrigger after 2nd tick
    step(2'b10, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    expect_both("retrig start", 2'b01, 2'b00, 1'b1);
    ticks(2);
    step(2'b10, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    for (int k = 0; k < 7; k++) step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b1);
    check("retrig rt hold t3", 32'(hold_rt), 32'(2'b01));
    check("retrig rt done t3", 32'(done_rt), 32'(2'b00));
    check("retrig nr hold t3", 32'(hold_nr), 32'(2'b00));
    check("retrig nr done t3", 32'(done_nr), 32'(2'b01));
    step(2'b11, 2'b00, 1'b0);
    check("retrig nr done 1 cycle", 32'(done_nr), 32'(2'b00));
    ticks(1);
    check("retrig rt hold t4", 32'(hold_rt), 32'(2'b01));
    ticks(1);
    check("retrig rt hold t5", 32'(hold_rt), 32'(2'b00));
    check("retrig rt done t5", 32'(done_rt), 32'(2'b01));
    check("retrig nr busy t5", 32'(busy_nr), 32'(1'b0));
    step(2'b11, 2'b00, 1'b0);
    check("retrig rt done 1 cycle", 32'(done_rt), 32'(2'b00));
    ticks(2);
    expect_both("retrig all idle", 2'b00, 2'b00, 1'b0);

    // Edge coincident with a tick: that tick is not counted
    step(2'b10, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b1);
    expect_both("coinc start", 2'b01, 2'b00, 1'b1);
    ticks(2);
    expect_both("coinc 2 ticks", 2'b01, 2'b00, 1'b1);
    ticks(1);
    expect_both("coinc end", 2'b00, 2'b01, 1'b1);

    // Asynchronous reset mid-hold
    ticks(2);
    step(2'b10, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    expect_both("pre reset hold", 2'b01, 2'b00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_both("async reset", 2'b00, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
